// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc -- shared NoC types and constants.
//   xy_t           : router coordinate (4-bit x, 4-bit y)
//   message_t      : 5-bit message type
//   preamble_t     : head/tail marks carried with every flit
//   packet_info_t  : head-flit contents {source, destination, message}
//   PortQueueDepth : slots in a downstream port queue (initial credit count)
//   CreditsWidth   : width of a credit counter able to hold PortQueueDepth
//   pkt_state_e    : packetizer FSM state
// -----------------------------------------------------------------------------
package noc;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
   } xy_t;

   typedef logic [4:0] message_t;

   typedef struct packed {
      logic head;
      logic tail;
   } preamble_t;

   typedef struct packed {
      xy_t      source;
      xy_t      destination;
      message_t message;
   } packet_info_t;

   localparam int PortQueueDepth = 2;
   localparam int CreditsWidth   = $clog2(PortQueueDepth + 1);

   typedef enum logic [1:0] {
      kIdle = 2'd0,
      kHead = 2'd1,
      kBody = 2'd2
   } pkt_state_e;

endpackage

// File: rtl/noc_credit_counter.sv
// -----------------------------------------------------------------------------
// noc_credit_counter -- tracks free slots in a downstream queue.
//   clk, rst   : clock, asynchronous active-high reset
//   consume    : a flit is sent this cycle (takes one slot)
//   credit_in  : downstream freed one slot this cycle
//   available  : current number of free slots (0..Depth)
//   overflow   : sticky, set when a credit arrives while already full
// The counter saturates at both ends; a consume and a credit in the same
// cycle cancel out.
// -----------------------------------------------------------------------------
module noc_credit_counter
   import noc::*;
#(
   parameter int Depth = PortQueueDepth,
   parameter int Width = CreditsWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             consume,
   input  logic             credit_in,
   output logic [Width-1:0] available,
   output logic             overflow
);

   localparam logic [Width-1:0] Full = Width'(Depth);

   logic [Width-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;

   always_comb begin
      count_d    = count_q;
      overflow_d = overflow_q;
      if (consume && !credit_in) begin
         // Callers only consume with credits available; the guard keeps
         // the counter from wrapping if that contract is ever broken.
         if (count_q != '0) count_d = count_q - 1'b1;
      end else if (credit_in && !consume) begin
         if (count_q == Full) overflow_d = 1'b1;
         else                 count_d    = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= Full;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign available = count_q;
   assign overflow  = overflow_q;

endmodule

// File: rtl/noc_packetizer.sv
// -----------------------------------------------------------------------------
// noc_packetizer -- turns a packet request plus a payload stream into flits.
//   clk, rst         : clock, asynchronous active-high reset
//   req_*            : packet request (valid/ready), destination, message,
//                      number of body flits
//   pl_*             : payload words (valid/ready), one per body flit
//   flit_*           : registered flit output, valid for one cycle per flit
//   credit_in        : downstream freed one queue slot
//   credit_overflow  : sticky protocol error (credit returned while full)
//   dbg_state        : current FSM state
//   dbg_credits      : current credit count
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; ready never depends on valid, and valid is not withdrawn by this
// block. A packet is one head flit followed by req_length body flits; the
// last flit carries tail=1.
// -----------------------------------------------------------------------------
module noc_packetizer
   import noc::*;
#(
   parameter xy_t LocalXY      = '0,
   parameter int  DataWidth    = 32,
   parameter int  MaxBodyFlits = 15,
   localparam int LenWidth     = $clog2(MaxBodyFlits + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  xy_t                     req_destination,
   input  message_t                req_message,
   input  logic [LenWidth-1:0]     req_length,
   input  logic                    pl_valid,
   output logic                    pl_ready,
   input  logic [DataWidth-1:0]    pl_data,
   output logic                    flit_valid,
   output preamble_t               flit_preamble,
   output logic [DataWidth-1:0]    flit_data,
   input  logic                    credit_in,
   output logic                    credit_overflow,
   output pkt_state_e              dbg_state,
   output logic [CreditsWidth-1:0] dbg_credits
);

   localparam int InfoWidth = $bits(packet_info_t);

   if (DataWidth < InfoWidth) begin : g_width_check
      $error("noc_packetizer: DataWidth must be at least $bits(packet_info_t)");
   end

   pkt_state_e                state_q, state_d;
   xy_t                       dest_q, dest_d;
   message_t                  msg_q, msg_d;
   logic [LenWidth-1:0]       len_q, len_d;
   logic [LenWidth-1:0]       remaining_q, remaining_d;
   logic                      flit_valid_q, flit_valid_d;
   preamble_t                 flit_preamble_q, flit_preamble_d;
   logic [DataWidth-1:0]      flit_data_q, flit_data_d;

   logic                      issue;
   logic                      has_credit;
   logic [CreditsWidth-1:0]   credits;
   logic [DataWidth-1:0]      head_data;

   noc_credit_counter #(
      .Depth (PortQueueDepth),
      .Width (CreditsWidth)
   ) u_credit (
      .clk       (clk),
      .rst       (rst),
      .consume   (issue),
      .credit_in (credit_in),
      .available (credits),
      .overflow  (credit_overflow)
   );

   assign has_credit = (credits != '0);

   always_comb begin
      state_d         = state_q;
      dest_d          = dest_q;
      msg_d           = msg_q;
      len_d           = len_q;
      remaining_d     = remaining_q;
      flit_valid_d    = 1'b0;
      // Preamble and data hold their last value between flits.
      flit_preamble_d = flit_preamble_q;
      flit_data_d     = flit_data_q;
      issue           = 1'b0;
      req_ready       = 1'b0;
      pl_ready        = 1'b0;

      head_data                = '0;
      head_data[InfoWidth-1:0] = {LocalXY, dest_q, msg_q};

      case (state_q)
         kIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               dest_d  = req_destination;
               msg_d   = req_message;
               len_d   = req_length;
               state_d = kHead;
            end
         end
         kHead: begin
            if (has_credit) begin
               issue                = 1'b1;
               flit_valid_d         = 1'b1;
               flit_preamble_d.head = 1'b1;
               flit_preamble_d.tail = (len_q == '0);
               flit_data_d          = head_data;
               remaining_d          = len_q;
               state_d              = (len_q == '0) ? kIdle : kBody;
            end
         end
         kBody: begin
            pl_ready = has_credit;
            if (pl_valid && has_credit) begin
               issue                = 1'b1;
               flit_valid_d         = 1'b1;
               flit_preamble_d.head = 1'b0;
               flit_preamble_d.tail = (remaining_q == LenWidth'(1));
               flit_data_d          = pl_data;
               remaining_d          = remaining_q - 1'b1;
               if (remaining_q == LenWidth'(1)) state_d = kIdle;
            end
         end
         default: state_d = kIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= kIdle;
         dest_q          <= '0;
         msg_q           <= '0;
         len_q           <= '0;
         remaining_q     <= '0;
         flit_valid_q    <= 1'b0;
         flit_preamble_q <= '0;
         flit_data_q     <= '0;
      end else begin
         state_q         <= state_d;
         dest_q          <= dest_d;
         msg_q           <= msg_d;
         len_q           <= len_d;
         remaining_q     <= remaining_d;
         flit_valid_q    <= flit_valid_d;
         flit_preamble_q <= flit_preamble_d;
         flit_data_q     <= flit_data_d;
      end
   end

   assign flit_valid    = flit_valid_q;
   assign flit_preamble = flit_preamble_q;
   assign flit_data     = flit_data_q;
   assign dbg_state     = state_q;
   assign dbg_credits   = credits;

endmodule
